pc_ras_unit: RTL and testbench

//   Parametrised program counter with a return-address stack (RAS), successor to the

---
 rtl/pc_ras_unit.sv | 141 ++++++++++++++
 tb/tb_pc_ras_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_unit
// Description : Program counter with a circular return-address stack.
//               The PC supports load, increment by STEP, signed relative
//               branch, call (push PC+STEP, jump to BUS) and return (pop into
//               PC), with a stall that freezes both PC and stack.
//               Strict priority, one action per cycle:
//               stall > pc_load > ret > call > branch > incr_pc > hold.
// Ports       : clk, rst (async, active-high)
//               BUS      - load/call target
//               pc_load, incr_pc, branch, call, ret, stall, err_clr - requests
//               offset   - signed two's-complement branch offset
//               pc       - current PC (registered)
//               ras_top  - top-of-stack entry, 0 when empty
//               ras_count/ras_empty/ras_full - stack occupancy
//               ras_ovf/ras_udf - sticky overflow / underflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_unit #(
    parameter int                 WIDTH    = 32,
    parameter int                 STEP     = 1,
    parameter int                 DEPTH    = 8,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            BUS,
    input  logic                        pc_load,
    input  logic                        incr_pc,
    input  logic                        branch,
    input  logic [WIDTH-1:0]            offset,
    input  logic                        call,
    input  logic                        ret,
    input  logic                        stall,
    input  logic                        err_clr,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            ras_top,
    output logic [$clog2(DEPTH+1)-1:0]  ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_ovf,
    output logic                        ras_udf
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W     = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] c_step    = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_max = PTR_W'(DEPTH-1);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [PTR_W-1:0] w_top_inc;
    logic [PTR_W-1:0] w_top_dec;
    logic             w_empty;
    logic             w_full;
    logic             w_do_ret;
    logic             w_do_call;
    logic             w_pop;

    assign w_pc_inc  = r_pc + c_step;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);

    // ret and call only act when nothing of higher priority is requested.
    assign w_do_ret  = !stall && !pc_load && ret;
    assign w_do_call = !stall && !pc_load && !ret && call;
    assign w_pop     = w_do_ret && !w_empty;

    // Top pointer wraps modulo DEPTH; a push while full therefore lands on
    // the oldest slot, discarding it.
    assign w_top_inc = (r_top == c_ptr_max) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? c_ptr_max : r_top - 1'b1;

    always_comb begin
        w_pc_nxt = r_pc;
        if (stall) begin
            w_pc_nxt = r_pc;
        end else if (pc_load) begin
            w_pc_nxt = BUS;
        end else if (ret) begin
            w_pc_nxt = w_empty ? w_pc_inc : r_stack[r_top];
        end else if (call) begin
            w_pc_nxt = BUS;
        end else if (branch) begin
            w_pc_nxt = r_pc + offset;
        end else if (incr_pc) begin
            w_pc_nxt = w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_do_call) begin
                r_top <= w_top_inc;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - 1'b1;
            end
            // A new error in the same cycle as err_clr leaves the flag set.
            r_ovf <= (r_ovf & ~err_clr) | (w_do_call & w_full);
            r_udf <= (r_udf & ~err_clr) | (w_do_ret & w_empty);
        end
    end

    // Stack storage needs no reset: entries are only visible through
    // ras_top, which is masked while the stack is empty.
    always_ff @(posedge clk) begin
        if (w_do_call) begin
            r_stack[w_top_inc] <= w_pc_inc;
        end
    end

    assign pc        = r_pc;
    assign ras_top   = w_empty ? '0 : r_stack[r_top];
    assign ras_count = r_count;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ras_unit
// Description : Self-checking bench for pc_ras_unit (WIDTH=32, STEP=1,
//               DEPTH=8). A behavioural model built on a queue stack
//               computes the expected state for every driven cycle; the
//               expectation is queued and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ras_unit;

    localparam int c_depth = 8;

    logic        clk;
    logic        rst;
    logic [31:0] BUS;
    logic        pc_load;
    logic        incr_pc;
    logic        branch;
    logic [31:0] offset;
    logic        call;
    logic        ret;
    logic        stall;
    logic        err_clr;
    logic [31:0] pc;
    logic [31:0] ras_top;
    logic [3:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_udf;

    pc_ras_unit #(
        .WIDTH    (32),
        .STEP     (1),
        .DEPTH    (c_depth),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .BUS       (BUS),
        .pc_load   (pc_load),
        .incr_pc   (incr_pc),
        .branch    (branch),
        .offset    (offset),
        .call      (call),
        .ret       (ret),
        .stall     (stall),
        .err_clr   (err_clr),
        .pc        (pc),
        .ras_top   (ras_top),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_udf   (ras_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] top;
        logic [31:0] count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    logic        m_ovf;
    logic        m_udf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.count = m_stack.size();
        e.top   = (m_stack.size() > 0) ? m_stack[$] : 32'h0;
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == c_depth);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, ".pc"},    pc,                e.pc);
            check_val({tag, ".top"},   ras_top,           e.top);
            check_val({tag, ".count"}, {28'h0, ras_count}, e.count);
            check_val({tag, ".empty"}, {31'h0, ras_empty}, {31'h0, e.empty});
            check_val({tag, ".full"},  {31'h0, ras_full},  {31'h0, e.full});
            check_val({tag, ".ovf"},   {31'h0, ras_ovf},   {31'h0, e.ovf});
            check_val({tag, ".udf"},   {31'h0, ras_udf},   {31'h0, e.udf});
        end
    endtask

    // One clock cycle: drive requests, advance the model, push expectation,
    // clock, then compare one cycle later.
    task automatic step(input string tag,
                        input logic i_ld, input logic i_ret, input logic i_call,
                        input logic i_br, input logic i_inc, input logic i_stall,
                        input logic i_clr, input logic [31:0] i_bus,
                        input logic [31:0] i_off);
        logic ovf_set;
        logic udf_set;
        pc_load = i_ld;  ret    = i_ret;   call    = i_call;
        branch  = i_br;  incr_pc = i_inc;  stall   = i_stall;
        err_clr = i_clr; BUS    = i_bus;   offset  = i_off;

        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (!i_stall) begin
            if (i_ld) begin
                m_pc = i_bus;
            end else if (i_ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc    = m_pc + 32'd1;
                    udf_set = 1'b1;
                end
            end else if (i_call) begin
                if (m_stack.size() == c_depth) begin
                    void'(m_stack.pop_front());
                    ovf_set = 1'b1;
                end
                m_stack.push_back(m_pc + 32'd1);
                m_pc = i_bus;
            end else if (i_br) begin
                m_pc = m_pc + i_off;
            end else if (i_inc) begin
                m_pc = m_pc + 32'd1;
            end
        end
        m_ovf = (m_ovf & ~i_clr) | ovf_set;
        m_udf = (m_udf & ~i_clr) | udf_set;
        sb_q.push_back(model_snapshot());

        @(posedge clk);
        #1;
        pc_load = 0; ret = 0; call = 0; branch = 0; incr_pc = 0;
        stall = 0; err_clr = 0;
        compare_out(tag);
    endtask

    // Shorthand wrappers for the common single-action cycles
    task automatic do_load(input logic [31:0] v);
        step("load", 1, 0, 0, 0, 0, 0, 0, v, 32'h0);
    endtask
    task automatic do_inc();
        step("incr", 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    endtask
    task automatic do_call(input logic [31:0] v);
        step("call", 0, 0, 1, 0, 0, 0, 0, v, 32'h0);
    endtask
    task automatic do_ret();
        step("ret", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask
    task automatic do_branch(input logic [31:0] off);
        step("branch", 0, 0, 0, 1, 0, 0, 0, 32'h0, off);
    endtask

    initial begin
        rst = 1'b1;
        BUS = '0; offset = '0;
        pc_load = 0; incr_pc = 0; branch = 0; call = 0; ret = 0;
        stall = 0; err_clr = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.pc",    pc, 32'h0);
        check_val("rst.count", {28'h0, ras_count}, 32'h0);
        check_val("rst.empty", {31'h0, ras_empty}, 32'h1);
        check_val("rst.full",  {31'h0, ras_full},  32'h0);
        check_val("rst.top",   ras_top, 32'h0);
        check_val("rst.flags", {30'h0, ras_ovf, ras_udf}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. Increment sequence, then async reset mid-run
        do_inc();
        do_inc();
        do_inc();
        check_val("t1.pc3", pc, 32'h3);
        do_call(32'h40);
        #2;
        rst = 1'b1;
        #1;
        check_val("t1.async_pc",    pc, 32'h0);
        check_val("t1.async_count", {28'h0, ras_count}, 32'h0);
        check_val("t1.async_empty", {31'h0, ras_empty}, 32'h1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2. Call / return round trip
        do_load(32'h10);
        do_call(32'h100);
        check_val("t2.top", ras_top, 32'h11);
        do_ret();
        check_val("t2.pc", pc, 32'h11);

        // 3. Fill past DEPTH, drain, then underflow
        do_load(32'h500);
        for (int i = 0; i < 9; i++) begin
            do_call(32'h1000 + 32'(i) * 32'h10);
        end
        check_val("t3.top", ras_top, 32'h1071);
        for (int i = 0; i < 9; i++) begin
            do_ret();
        end
        step("clr", 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);

        // 4. Branches and wrap
        do_load(32'h20);
        do_branch(32'hFFFF_FFFC);
        check_val("t4.br_neg", pc, 32'h1C);
        do_load(32'hFFFF_FFFF);
        do_inc();
        do_branch(32'h8);
        check_val("t4.br_pos", pc, 32'h8);

        // 5. Priority
        do_call(32'h200);
        step("ld_ret_call", 1, 1, 1, 1, 1, 0, 0, 32'h300, 32'h4);
        step("stall_call",  0, 0, 1, 0, 1, 1, 0, 32'h400, 32'h0);
        step("ret_call",    0, 1, 1, 0, 0, 0, 0, 32'h500, 32'h0);
        step("call_br",     0, 0, 1, 1, 1, 0, 0, 32'h600, 32'h10);
        step("br_inc",      0, 0, 0, 1, 1, 0, 0, 32'h0,   32'h10);
        do_ret();
        step("clr_udf",     0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        step("stall_clr",   0, 1, 0, 0, 0, 1, 1, 32'h0, 32'h0);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), $urandom(), $urandom());
        end

        check_val("sb.drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
